// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-requester arbiter on the 2:1 data-select path.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_arb21_rr_pick.sv
// Combinational two-way round-robin picker: pri breaks ties, a lone requester always wins.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic A_valid,
  input  logic B_valid,
  input  logic pri,
  output logic grant_valid,
  output logic grant_sel
);

  assign grant_valid = A_valid | B_valid;
  assign grant_sel   = (A_valid && B_valid) ? pri : (B_valid ? SEL_B : SEL_A);

endmodule

// File: rtl/mux_arb21.sv
// Round-robin burst arbiter feeding one registered valid/ready output stage from requester A or B.
module mux_arb21
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A_valid,
  input  logic [WIDTH-1:0] A_data,
  input  logic             A_last,
  output logic             A_ready,
  input  logic             B_valid,
  input  logic [WIDTH-1:0] B_data,
  input  logic             B_last,
  output logic             B_ready,
  output logic             Y_valid,
  output logic [WIDTH-1:0] Y_data,
  output logic             Y_last,
  input  logic             Y_ready,
  output logic             S,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t             state_reg, state_next;
  logic               pri_reg, pri_next;
  logic               s_reg, s_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               y_valid_reg, y_valid_next;
  logic [WIDTH-1:0]   y_data_reg, y_data_next;
  logic               y_last_reg, y_last_next;

  logic               grant_valid, grant_sel;
  logic               out_free, x_valid, x_last, xfer, at_limit;
  logic [WIDTH-1:0]   x_data;

  rr_pick u_pick (
    .A_valid     (A_valid),
    .B_valid     (B_valid),
    .pri         (pri_reg),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  // Ready depends only on state and the output slot, never on the requester's valid.
  assign out_free = !y_valid_reg || Y_ready;
  assign A_ready  = (state_reg == GNT_A) && out_free;
  assign B_ready  = (state_reg == GNT_B) && out_free;

  assign x_valid  = (state_reg == GNT_B) ? B_valid : A_valid;
  assign x_data   = (state_reg == GNT_B) ? B_data  : A_data;
  assign x_last   = (state_reg == GNT_B) ? B_last  : A_last;
  assign xfer     = x_valid && (A_ready || B_ready);
  assign at_limit = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next   = state_reg;
    pri_next     = pri_reg;
    s_next       = s_reg;
    cnt_next     = cnt_reg;
    y_valid_next = y_valid_reg;
    y_data_next  = y_data_reg;
    y_last_next  = y_last_reg;

    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next = (grant_sel == SEL_B) ? GNT_B : GNT_A;
          s_next     = grant_sel;
        end
      end
      GNT_A, GNT_B: begin
        if (xfer && (x_last || at_limit)) begin
          state_next = IDLE;
          cnt_next   = '0;
          pri_next   = (state_reg == GNT_A) ? SEL_B : SEL_A;
        end else if (xfer) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (xfer) begin
      y_valid_next = 1'b1;
      y_data_next  = x_data;
      y_last_next  = x_last || at_limit;
    end else if (Y_ready) begin
      y_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pri_reg     <= SEL_A;
      s_reg       <= SEL_A;
      cnt_reg     <= '0;
      y_valid_reg <= 1'b0;
      y_data_reg  <= '0;
      y_last_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pri_reg     <= pri_next;
      s_reg       <= s_next;
      cnt_reg     <= cnt_next;
      y_valid_reg <= y_valid_next;
      y_data_reg  <= y_data_next;
      y_last_reg  <= y_last_next;
    end
  end

  assign Y_valid = y_valid_reg;
  assign Y_data  = y_data_reg;
  assign Y_last  = y_last_reg;
  assign S       = s_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_mux_arb21.sv
// Directed scenarios plus randomized traffic for mux_arb21, checked every cycle against a grant-level model.
module tb_mux_arb21;

  localparam int W  = 16;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         A_valid = 1'b0, A_last = 1'b0, B_valid = 1'b0, B_last = 1'b0;
  logic [W-1:0] A_data = '0, B_data = '0;
  logic         A_ready, B_ready, Y_valid, Y_last, S, busy;
  logic [W-1:0] Y_data;
  logic         Y_ready = 1'b1;

  always #5 clk = ~clk;

  mux_arb21 #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .A_valid(A_valid), .A_data(A_data), .A_last(A_last), .A_ready(A_ready),
    .B_valid(B_valid), .B_data(B_data), .B_last(B_last), .B_ready(B_ready),
    .Y_valid(Y_valid), .Y_data(Y_data), .Y_last(Y_last), .Y_ready(Y_ready),
    .S(S), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Grant-level model: who owns the path, beats taken, and the single output slot.
  int           m_owner = -1;
  int           m_beats = 0;
  bit           m_pri = 0, m_s = 0, m_yv = 0, m_yl = 0;
  logic [W-1:0] m_yd = '0;
  logic [16:0]  ylog[$];

  always @(negedge clk) begin
    bit           ear, ebr, fire, lst;
    logic [W-1:0] d;
    if (!rst_n) begin
      m_owner = -1; m_beats = 0; m_pri = 0; m_s = 0; m_yv = 0; m_yl = 0; m_yd = '0;
    end
    ear = (m_owner == 0) && (!m_yv || Y_ready);
    ebr = (m_owner == 1) && (!m_yv || Y_ready);
    chk("A_ready", A_ready, ear);
    chk("B_ready", B_ready, ebr);
    chk("Y_valid", Y_valid, m_yv);
    chk("Y_data",  Y_data,  m_yd);
    chk("Y_last",  Y_last,  m_yl);
    chk("S",       S,       m_s);
    chk("busy",    busy,    m_owner >= 0);
    if (rst_n) begin
      if (Y_valid && Y_ready) begin
        ylog.push_back({Y_last, Y_data});
        $display("beat Y_data=%h Y_last=%b t=%0t", Y_data, Y_last, $time);
      end
      fire = 0; lst = 0; d = '0;
      if (m_owner < 0) begin
        if (A_valid && (!B_valid || !m_pri)) begin m_owner = 0; m_s = 0; end
        else if (B_valid) begin m_owner = 1; m_s = 1; end
      end else if (m_owner == 0) begin
        fire = A_valid && ear; d = A_data; lst = A_last;
      end else begin
        fire = B_valid && ebr; d = B_data; lst = B_last;
      end
      if (fire) begin
        m_yv = 1; m_yd = d; m_yl = lst || (m_beats == MB - 1);
        m_beats++;
        if (m_yl) begin
          m_pri = (m_owner == 0);
          m_owner = -1;
          m_beats = 0;
        end
      end else if (Y_ready) begin
        m_yv = 0;
      end
    end
  end

  logic [W-1:0] aq[$], bq[$];
  bit           al[$], bl[$];
  bit           a_en = 1, b_en = 1;

  task automatic one_cycle(output bit fa, output bit fb);
    A_valid = a_en && (aq.size() > 0);
    A_data  = (aq.size() > 0) ? aq[0] : '0;
    A_last  = (al.size() > 0) ? al[0] : 1'b0;
    B_valid = b_en && (bq.size() > 0);
    B_data  = (bq.size() > 0) ? bq[0] : '0;
    B_last  = (bl.size() > 0) ? bl[0] : 1'b0;
    @(negedge clk);
    fa = A_valid && A_ready;
    fb = B_valid && B_ready;
    @(posedge clk);
    #1;
    if (fa) begin void'(aq.pop_front()); void'(al.pop_front()); end
    if (fb) begin void'(bq.pop_front()); void'(bl.pop_front()); end
  endtask

  task automatic run(int n);
    bit fa, fb;
    repeat (n) one_cycle(fa, fb);
  endtask

  initial begin
    bit fa, fb, done;
    int nf, nlast;
    logic [16:0] e;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_Y_valid", Y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_S", S, 0);
    chk("rst_A_ready", A_ready, 0);
    rst_n = 1'b1;

    // Single requester A, three words with last on the third
    ylog.delete();
    aq = '{16'h1111, 16'h2222, 16'h3333}; al = '{0, 0, 1};
    run(8);
    chk("t_single_count", ylog.size(), 3);
    if (ylog.size() == 3) begin
      chk("t_single_w0", ylog[0], 17'h01111);
      chk("t_single_w1", ylog[1], 17'h02222);
      chk("t_single_w2", ylog[2], 17'h13333);
    end

    // Contention: pri now favours B, so B4, A4, B4 with a last on every 4th word
    ylog.delete();
    for (int i = 0; i < 4; i++) begin aq.push_back(16'hA000 + 16'(i)); al.push_back(0); end
    for (int i = 0; i < 8; i++) begin bq.push_back(16'hB000 + 16'(i)); bl.push_back(0); end
    run(30);
    chk("t_cont_count", ylog.size(), 12);
    if (ylog.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        e[16]   = (i % 4 == 3);
        e[15:0] = ((i / 4) == 1) ? 16'hA000 + 16'(i % 4) : 16'hB000 + 16'(((i / 4) == 2 ? 4 : 0) + i % 4);
        chk("t_cont_word", ylog[i], e);
      end
    end

    // Backpressure on 0xBEEF during a B burst; B_last coincides with the beat limit
    ylog.delete();
    bq = '{16'h0B01, 16'hBEEF, 16'h0B03, 16'h0B04}; bl = '{0, 0, 0, 1};
    done = 0;
    for (int i = 0; i < 20; i++) begin
      if (!done && Y_valid && Y_data == 16'hBEEF) begin
        Y_ready = 1'b0;
        repeat (3) begin
          one_cycle(fa, fb);
          chk("t_bp_hold", Y_data, 16'hBEEF);
          chk("t_bp_B_ready", B_ready, 0);
          chk("t_bp_fire", fb, 0);
        end
        Y_ready = 1'b1;
        done = 1;
      end
      one_cycle(fa, fb);
    end
    chk("t_bp_stall_seen", done, 1);
    chk("t_bp_count", ylog.size(), 4);
    nlast = 0;
    foreach (ylog[i]) nlast += int'(ylog[i][16]);
    chk("t_bp_one_last", nlast, 1);
    if (ylog.size() == 4) begin
      chk("t_bp_w1", ylog[1], 17'h0BEEF);
      chk("t_bp_w3", ylog[3], 17'h10B04);
    end

    // Granted A goes quiet mid-burst while B waits; pri favours A after B was served
    ylog.delete();
    aq = '{16'h00A1, 16'h00A2}; al = '{0, 1};
    bq = '{16'h00B1}; bl = '{1};
    nf = 0;
    for (int i = 0; i < 10 && nf == 0; i++) begin
      one_cycle(fa, fb);
      if (fa) nf++;
    end
    chk("t_idle_first_fire", nf, 1);
    a_en = 0;
    repeat (5) begin
      one_cycle(fa, fb);
      chk("t_idle_busy", busy, 1);
      chk("t_idle_S", S, 0);
      chk("t_idle_B_ready", B_ready, 0);
    end
    a_en = 1;
    run(12);
    chk("t_idle_count", ylog.size(), 3);
    if (ylog.size() == 3) begin
      chk("t_idle_w0", ylog[0], 17'h000A1);
      chk("t_idle_w1", ylog[1], 17'h100A2);
      chk("t_idle_w2", ylog[2], 17'h100B1);
    end

    // Asynchronous reset in the middle of a B burst
    for (int i = 0; i < 8; i++) begin bq.push_back(16'hC000 + 16'(i)); bl.push_back(0); end
    nf = 0;
    for (int i = 0; i < 12 && nf < 2; i++) begin
      one_cycle(fa, fb);
      if (fb) nf++;
    end
    chk("t_rst_fires", nf, 2);
    chk("t_rst_pre_S", S, 1);
    chk("t_rst_pre_Y_valid", Y_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t_rst_Y_valid", Y_valid, 0);
    chk("t_rst_Y_data", Y_data, 0);
    chk("t_rst_Y_last", Y_last, 0);
    chk("t_rst_busy", busy, 0);
    chk("t_rst_S", S, 0);
    chk("t_rst_B_ready", B_ready, 0);
    bq.delete(); bl.delete();
    B_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t_rst_after_S", S, 0);
    chk("t_rst_after_busy", busy, 0);

    // Randomized traffic with random stalls and valid drops
    for (int i = 0; i < 1500; i++) begin
      if (aq.size() < 2) begin aq.push_back(16'($urandom)); al.push_back($urandom_range(0, 4) == 0); end
      if (bq.size() < 2) begin bq.push_back(16'($urandom)); bl.push_back($urandom_range(0, 4) == 0); end
      a_en    = ($urandom_range(0, 9) < 8);
      b_en    = ($urandom_range(0, 9) < 8);
      Y_ready = ($urandom_range(0, 9) < 7);
      one_cycle(fa, fb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
